// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer
// Produces the 4-bit index that drives a 4-to-16 one-hot decoder. The index
// steps from 0 up to a captured LAST and holds each value for DWELL+1 enabled
// cycles. In single-sweep mode it returns to idle after the sweep. In
// continuous mode it wraps back to 0. TICK marks each new index after the
// first one, and DONE marks the end of each sweep. Every output is a flop.
module decoder_scan_sequencer #(
  parameter int DWELL_WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   ASYNCRESET,
  input  logic                   EN,
  input  logic                   MODE,
  input  logic                   START,
  input  logic                   STOP,
  input  logic [3:0]             LAST,
  input  logic [DWELL_WIDTH-1:0] DWELL,
  output logic [3:0]             O,
  output logic                   VALID,
  output logic                   TICK,
  output logic                   DONE
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic [DWELL_WIDTH-1:0] CNT_ZERO = {DWELL_WIDTH{1'b0}};
  localparam logic [DWELL_WIDTH-1:0] CNT_ONE  = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

  // Sequencer state and parameters captured when a START is accepted
  state_t                 state_q, state_d;
  logic [DWELL_WIDTH-1:0] cnt_q,   cnt_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [3:0]             last_q,  last_d;
  logic                   mode_q,  mode_d;

  // Output flops
  logic [3:0]             o_q,     o_d;
  logic                   valid_q, valid_d;
  logic                   tick_q,  tick_d;
  logic                   done_q,  done_d;

  // Next-state logic: accept START in idle, step through indices while scanning
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    last_d  = last_q;
    mode_d  = mode_q;
    o_d     = o_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        o_d   = 4'd0;
        cnt_d = CNT_ZERO;
        if (START && !STOP && EN) begin
          // The captured values stay fixed for the whole run.
          last_d  = LAST;
          dwell_d = DWELL;
          mode_d  = MODE;
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SCAN: begin
        if (STOP) begin
          // An abort ends the sweep without a DONE or TICK pulse.
          state_d = ST_IDLE;
          o_d     = 4'd0;
          cnt_d   = CNT_ZERO;
        end else if (!EN) begin
          state_d = ST_SCAN;
        end else if (cnt_q < dwell_q) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = CNT_ZERO;
          if (o_q != last_q) begin
            o_d    = o_q + 4'd1;
            tick_d = 1'b1;
          end else if (mode_q) begin
            // End of a single sweep: return to idle.
            state_d = ST_IDLE;
            o_d     = 4'd0;
            done_d  = 1'b1;
          end else begin
            // End of a continuous sweep: wrap to 0, which also counts as a new index.
            o_d    = 4'd0;
            done_d = 1'b1;
            tick_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        o_d     = 4'd0;
        cnt_d   = CNT_ZERO;
      end
    endcase

    valid_d = (state_d == ST_SCAN);
  end

  // State and output registers, cleared immediately by ASYNCRESET
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      dwell_q <= CNT_ZERO;
      last_q  <= 4'd0;
      mode_q  <= 1'b0;
      o_q     <= 4'd0;
      valid_q <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      last_q  <= last_d;
      mode_q  <= mode_d;
      o_q     <= o_d;
      valid_q <= valid_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign O     = o_q;
  assign VALID = valid_q;
  assign TICK  = tick_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed self-checking bench for decoder_scan_sequencer.
module tb_decoder_scan_sequencer;

  logic       CLK;
  logic       ASYNCRESET;
  logic       EN;
  logic       MODE;
  logic       START;
  logic       STOP;
  logic [3:0] LAST;
  logic [7:0] DWELL;
  logic [3:0] O;
  logic       VALID;
  logic       TICK;
  logic       DONE;

  int checks = 0;
  int errors = 0;

  decoder_scan_sequencer #(.DWELL_WIDTH(8)) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .EN         (EN),
    .MODE       (MODE),
    .START      (START),
    .STOP       (STOP),
    .LAST       (LAST),
    .DWELL      (DWELL),
    .O          (O),
    .VALID      (VALID),
    .TICK       (TICK),
    .DONE       (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eo, input logic ev,
                         input logic et, input logic ed);
    chk({tag, ".O"},     {4'd0, O},     {4'd0, eo});
    chk({tag, ".VALID"}, {7'd0, VALID}, {7'd0, ev});
    chk({tag, ".TICK"},  {7'd0, TICK},  {7'd0, et});
    chk({tag, ".DONE"},  {7'd0, DONE},  {7'd0, ed});
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin : stim
    logic [3:0] exp_o;
    logic       exp_t;
    logic       exp_d;
    int         vcnt;
    int         tcnt;
    int         cyc;

    ASYNCRESET = 1'b1;
    EN = 1'b1; MODE = 1'b0; START = 1'b0; STOP = 1'b0;
    LAST = 4'd0; DWELL = 8'd0;

    // Reset state
    step();
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    ASYNCRESET = 1'b0;
    step(); step(); step();
    chk_all("idle_after_reset", 4'd0, 1'b0, 1'b0, 1'b0);

    // EN=0 blocks START in idle
    EN = 1'b0; START = 1'b1; MODE = 1'b1; LAST = 4'd3; DWELL = 8'd1;
    step();
    chk_all("start_en0", 4'd0, 1'b0, 1'b0, 1'b0);
    EN = 1'b1; START = 1'b0;
    step();

    // Single sweep: MODE=1 LAST=3 DWELL=1
    START = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) START = 1'b0;
      exp_o = 4'((c - 1) / 2);
      exp_t = (c == 3) || (c == 5) || (c == 7);
      chk_all($sformatf("single_c%0d", c), exp_o, 1'b1, exp_t, 1'b0);
    end
    step();
    chk_all("single_c9", 4'd0, 1'b0, 1'b0, 1'b1);
    step();
    chk_all("single_c10", 4'd0, 1'b0, 1'b0, 1'b0);

    // LAST=0 DWELL=0 single sweep: one index, then DONE
    MODE = 1'b1; LAST = 4'd0; DWELL = 8'd0; START = 1'b1;
    step(); START = 1'b0;
    chk_all("last0_c1", 4'd0, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("last0_c2", 4'd0, 1'b0, 1'b0, 1'b1);

    // Continuous sweep: MODE=0 LAST=15 DWELL=0
    MODE = 1'b0; LAST = 4'd15; DWELL = 8'd0; START = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      step();
      if (c == 1) START = 1'b0;
      exp_o = 4'((c - 1) % 16);
      exp_t = (c > 1);
      exp_d = (c > 1) && (((c - 1) % 16) == 0);
      chk_all($sformatf("cont_c%0d", c), exp_o, 1'b1, exp_t, exp_d);
    end
    STOP = 1'b1;
    step(); STOP = 1'b0;
    chk_all("cont_stop", 4'd0, 1'b0, 1'b0, 1'b0);

    // Pause: MODE=1 LAST=2 DWELL=3, EN=0 for 5 cycles after cycle 2
    MODE = 1'b1; LAST = 4'd2; DWELL = 8'd3; START = 1'b1;
    vcnt = 0; tcnt = 0;
    step(); START = 1'b0;
    if (VALID) vcnt++;
    step();
    if (VALID) vcnt++;
    EN = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (VALID) vcnt++;
      chk_all($sformatf("pause_c%0d", c), 4'd0, 1'b1, 1'b0, 1'b0);
    end
    EN = 1'b1;
    cyc = 0;
    while (VALID && cyc < 40) begin
      step();
      cyc++;
      if (VALID) vcnt++;
      if (TICK) tcnt++;
    end
    chk("pause_bound", {7'd0, (cyc < 40)}, 8'd1);
    chk("pause_done", {7'd0, DONE}, 8'd1);
    chk("pause_valid_cycles", 8'(vcnt), 8'd17);
    chk("pause_ticks", 8'(tcnt), 8'd2);

    // STOP at O=2 ends without DONE
    MODE = 1'b1; LAST = 4'd5; DWELL = 8'd0; START = 1'b1;
    step(); START = 1'b0;
    step(); step();
    chk_all("stop_at2", 4'd2, 1'b1, 1'b1, 1'b0);
    STOP = 1'b1;
    step(); STOP = 1'b0;
    chk_all("stop_c1", 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("stop_c2", 4'd0, 1'b0, 1'b0, 1'b0);

    // START together with STOP in idle: stays idle
    START = 1'b1; STOP = 1'b1;
    step();
    START = 1'b0; STOP = 1'b0;
    chk_all("start_stop", 4'd0, 1'b0, 1'b0, 1'b0);

    // LAST and MODE changed mid-sweep: captured values still apply
    MODE = 1'b1; LAST = 4'd3; DWELL = 8'd0; START = 1'b1;
    step(); START = 1'b0;
    LAST = 4'd1; MODE = 1'b0;
    chk_all("chg_c1", 4'd0, 1'b1, 1'b0, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      step();
      chk_all($sformatf("chg_c%0d", c), 4'(c - 1), 1'b1, 1'b1, 1'b0);
    end
    step();
    chk_all("chg_end", 4'd0, 1'b0, 1'b0, 1'b1);

    // START while scanning is ignored (no restart at 0)
    MODE = 1'b1; LAST = 4'd4; DWELL = 8'd0; START = 1'b1;
    step();
    step(); step();
    START = 1'b0;
    chk_all("start_in_scan", 4'd2, 1'b1, 1'b1, 1'b0);
    STOP = 1'b1;
    step(); STOP = 1'b0;

    // Reset mid-sweep at O=5 in continuous mode
    MODE = 1'b0; LAST = 4'd15; DWELL = 8'd0; START = 1'b1;
    step(); START = 1'b0;
    for (int c = 2; c <= 6; c++) step();
    chk_all("pre_reset", 4'd5, 1'b1, 1'b1, 1'b0);
    #2 ASYNCRESET = 1'b1;
    #1;
    chk_all("mid_reset", 4'd0, 1'b0, 1'b0, 1'b0);
    #2 ASYNCRESET = 1'b0;
    START = 1'b1;
    step(); START = 1'b0;
    chk_all("restart_c1", 4'd0, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("restart_c2", 4'd1, 1'b1, 1'b1, 1'b0);
    STOP = 1'b1;
    step(); STOP = 1'b0;
    chk_all("restart_stop", 4'd0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
